// File: rtl/uart_core_fifo.sv
// Parametrised UART: FIFO-buffered TX serializer and oversampled RX deserializer.
// Per-entry parity/frame error flags, RX overrun pulse, occupancy levels.
module uart_core_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic          do_push;
  logic          do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

module uart_core_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rxd,
  output logic                         txd,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]  tx_level,
  output logic [$clog2(FIFO_DEPTH):0]  rx_level
);
  localparam int BD    = BAUD * OVERSAMPLE;
  localparam int DIV_R = (BD > 0) ? (CLK_FREQ + BD / 2) / BD : 1;
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BD <= 0) begin : g_bad_param
    $error("uart_core_fifo: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = div_cnt == CW'(DIV - 1);

  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + CW'(1);
  end

  // ---- TX ----
  state_t               tx_st;
  logic [OW-1:0]        tx_tc;
  logic [BW-1:0]        tx_bi;
  logic                 tx_sc;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_pb;
  logic [DATA_BITS-1:0] tx_q;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_bit_end;
  logic                 tx_pop;

  assign tx_ready   = !tx_full;
  assign tx_bit_end = tick && tx_tc == OW'(OVERSAMPLE - 1);
  // last stop bit can chain straight into the next start bit
  assign tx_pop = tick && !tx_empty &&
                  (tx_st == S_IDLE ||
                   (tx_st == S_STOP && tx_bit_end &&
                    tx_sc == 1'(STOP_BITS - 1)));

  uart_core_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_q),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= S_IDLE;
      tx_tc <= '0;
      tx_bi <= '0;
      tx_sc <= 1'b0;
      tx_sh <= '0;
      tx_pb <= 1'b0;
      txd   <= 1'b1;
    end else if (tx_pop) begin
      tx_st <= S_START;
      tx_tc <= '0;
      tx_sh <= tx_q;
      tx_pb <= (PARITY == 1) ? ~^tx_q : ^tx_q;
      txd   <= 1'b0;
    end else if (tick && tx_st != S_IDLE) begin
      if (!tx_bit_end) begin
        tx_tc <= tx_tc + OW'(1);
      end else begin
        tx_tc <= '0;
        unique case (tx_st)
          S_START: begin
            tx_st <= S_DATA;
            tx_bi <= '0;
            txd   <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
          S_DATA: begin
            if (tx_bi == BW'(DATA_BITS - 1)) begin
              tx_sc <= 1'b0;
              if (PARITY != 0) begin
                tx_st <= S_PARITY;
                txd   <= tx_pb;
              end else begin
                tx_st <= S_STOP;
                txd   <= 1'b1;
              end
            end else begin
              tx_bi <= tx_bi + BW'(1);
              txd   <= tx_sh[0];
              tx_sh <= tx_sh >> 1;
            end
          end
          S_PARITY: begin
            tx_st <= S_STOP;
            txd   <= 1'b1;
          end
          S_STOP: begin
            if (tx_sc == 1'(STOP_BITS - 1)) tx_st <= S_IDLE;
            else tx_sc <= 1'b1;
          end
          default: tx_st <= S_IDLE;
        endcase
      end
    end
  end

  // ---- RX ----
  logic [1:0]           rx_sync;
  logic                 rx_s;
  state_t               rx_st;
  logic [OW-1:0]        rx_tc;
  logic [BW-1:0]        rx_bi;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pb;
  logic                 rx_mid;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_perr;
  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS+1:0] rx_q;

  assign rx_s    = rx_sync[1];
  assign rx_mid  = tick && rx_tc == OW'(OVERSAMPLE - 1);
  assign rx_push = rx_mid && rx_st == S_STOP;
  assign rx_perr = (PARITY != 0) &&
                   (rx_pb != ((PARITY == 1) ? ~^rx_sh : ^rx_sh));
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign {rx_frame_err, rx_parity_err, rx_data} = rx_q;

  uart_core_fifo_buf #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata ({!rx_s, rx_perr, rx_sh}),
    .pop   (rx_pop),
    .rdata (rx_q),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync    <= 2'b11;
      rx_overrun <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], rxd};
      rx_overrun <= rx_push && rx_full && !rx_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= S_IDLE;
      rx_tc <= '0;
      rx_bi <= '0;
      rx_sh <= '0;
      rx_pb <= 1'b0;
    end else if (tick) begin
      rx_tc <= rx_mid ? '0 : rx_tc + OW'(1);
      unique case (rx_st)
        S_IDLE: begin
          rx_tc <= '0;
          if (!rx_s) rx_st <= S_START;
        end
        S_START: begin
          // half-bit re-check rejects short low glitches
          if (rx_tc == OW'(OVERSAMPLE / 2 - 1)) begin
            rx_tc <= '0;
            rx_bi <= '0;
            rx_st <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_mid) begin
            rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
            rx_bi <= rx_bi + BW'(1);
            if (rx_bi == BW'(DATA_BITS - 1))
              rx_st <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (rx_mid) begin
            rx_pb <= rx_s;
            rx_st <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_mid) rx_st <= S_IDLE;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core_fifo.sv
// Directed bench for uart_core_fifo: 8N1 instance u0 and 8E1 instance u1.
// 11.0592 MHz / 115200 baud / x16 gives 96 clk per bit.
module tb_uart_core_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       loop0 = 1'b0, loop1 = 1'b0;
  logic       rxd_b0 = 1'b1, rxd_b1 = 1'b1;
  logic       rxd0, rxd1, txd0, txd1;
  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
  logic       tx_ready0, tx_ready1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_perr0, rx_perr1, rx_ferr0, rx_ferr1;
  logic       rx_valid0, rx_valid1;
  logic       rx_ready0 = 1'b0, rx_ready1 = 1'b0;
  logic       rx_overrun0, rx_overrun1;
  logic [4:0] tx_level0, tx_level1, rx_level0, rx_level1;

  assign rxd0 = loop0 ? txd0 : rxd_b0;
  assign rxd1 = loop1 ? txd1 : rxd_b1;

  uart_core_fifo #(
    .CLK_FREQ(11_059_200), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u0 (
    .clk(clk), .rst(rst), .rxd(rxd0), .txd(txd0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_parity_err(rx_perr0),
    .rx_frame_err(rx_ferr0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .rx_overrun(rx_overrun0),
    .tx_level(tx_level0), .rx_level(rx_level0)
  );

  uart_core_fifo #(
    .CLK_FREQ(11_059_200), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .txd(txd1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_parity_err(rx_perr1),
    .rx_frame_err(rx_ferr1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .rx_overrun(rx_overrun1),
    .tx_level(tx_level1), .rx_level(rx_level1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic ovr_clr = 1'b1;
  int   ovr_cnt;
  always @(posedge clk) begin
    if (ovr_clr) ovr_cnt <= 0;
    else if (rx_overrun0) ovr_cnt <= ovr_cnt + 1;
  end

  logic       mon_en = 1'b0;
  logic [7:0] rxq[$];
  always @(posedge clk) begin
    if (mon_en && rx_valid0 && rx_ready0) rxq.push_back(rx_data0);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bfm_bit(input bit w, input bit b);
    if (w) rxd_b1 = b;
    else rxd_b0 = b;
    repeat (96) @(negedge clk);
  endtask

  task automatic bfm_frame(input bit w, input logic [7:0] d,
                           input bit pen, input bit pbit, input bit stopv);
    bfm_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) bfm_bit(w, d[i]);
    if (pen) bfm_bit(w, pbit);
    bfm_bit(w, stopv);
    bfm_bit(w, 1'b1);
  endtask

  task automatic wait_valid(input bit w, input int budget, output bit ok);
    int n;
    n = 0;
    while (!(w ? rx_valid1 : rx_valid0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = w ? rx_valid1 : rx_valid0;
  endtask

  task automatic wait_fall(input bit w, input int budget, output bit ok);
    int n;
    n = 0;
    while ((w ? txd1 : txd0) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (w ? txd1 : txd0) === 1'b0;
  endtask

  task automatic pop0();
    rx_ready0 = 1'b1;
    @(negedge clk);
    rx_ready0 = 1'b0;
  endtask

  task automatic pop1();
    rx_ready1 = 1'b1;
    @(negedge clk);
    rx_ready1 = 1'b0;
  endtask

  initial begin
    bit         ok;
    int         n;
    int         k;
    bit         acc;
    bit         saw_full;
    bit         rdy_at_full;
    logic [7:0] a5;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(txd0), 1);
    check("rst_tx_ready", 32'(tx_ready0), 1);
    check("rst_rx_valid", 32'(rx_valid0), 0);
    check("rst_overrun", 32'(rx_overrun0), 0);
    check("rst_tx_level", 32'(tx_level0), 0);
    check("rst_rx_level", 32'(rx_level0), 0);
    check("rst_rx_data", 32'({rx_ferr0, rx_perr0, rx_data0}), 0);
    check("rst_txd_u1", 32'(txd1), 1);

    // 1: 8N1 loopback of 0xA5
    loop0 = 1'b1;
    tx_data0 = 8'hA5;
    tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    wait_fall(1'b0, 500, ok);
    check("t1_start_seen", 32'(ok), 1);
    n = 0;
    while (txd0 === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t1_start_len", 32'(n), 96);
    repeat (48) @(negedge clk);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_bit%0d", i), 32'(txd0), 32'(a5[i]));
      repeat (96) @(negedge clk);
    end
    check("t1_stop", 32'(txd0), 1);
    wait_valid(1'b0, 2000, ok);
    check("t1_rx_wait", 32'(ok), 1);
    check("t1_rx_data", 32'(rx_data0), 32'h A5);
    check("t1_rx_errs", 32'({rx_ferr0, rx_perr0}), 0);
    check("t1_rx_level", 32'(rx_level0), 1);
    pop0();
    check("t1_rx_level_pop", 32'(rx_level0), 0);
    loop0 = 1'b0;

    // 2: even parity on u1
    loop1 = 1'b1;
    tx_data1 = 8'h07;
    tx_valid1 = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    wait_fall(1'b1, 500, ok);
    check("t2_start_seen", 32'(ok), 1);
    repeat (48 + 96 * 9) @(negedge clk);
    check("t2_parity_bit", 32'(txd1), 1);
    repeat (96) @(negedge clk);
    check("t2_stop", 32'(txd1), 1);
    wait_valid(1'b1, 2000, ok);
    check("t2_rx_wait", 32'(ok), 1);
    check("t2_rx_data", 32'(rx_data1), 32'h07);
    check("t2_rx_perr_ok", 32'(rx_perr1), 0);
    pop1();
    loop1 = 1'b0;
    repeat (200) @(negedge clk);
    bfm_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_valid(1'b1, 500, ok);
    check("t2_bad_wait", 32'(ok), 1);
    check("t2_bad_data", 32'(rx_data1), 32'h07);
    check("t2_bad_perr", 32'(rx_perr1), 1);
    check("t2_bad_ferr", 32'(rx_ferr1), 0);
    pop1();

    // 3: frame error then clean frame
    bfm_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    bfm_bit(1'b0, 1'b1);
    wait_valid(1'b0, 500, ok);
    check("t3_ferr_wait", 32'(ok), 1);
    check("t3_ferr_data", 32'(rx_data0), 32'h3C);
    check("t3_ferr_flag", 32'(rx_ferr0), 1);
    check("t3_ferr_perr", 32'(rx_perr0), 0);
    check("t3_ferr_level", 32'(rx_level0), 1);
    pop0();
    bfm_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 500, ok);
    check("t3_good_wait", 32'(ok), 1);
    check("t3_good_data", 32'(rx_data0), 32'h55);
    check("t3_good_errs", 32'({rx_ferr0, rx_perr0}), 0);
    check("t3_good_level", 32'(rx_level0), 1);
    pop0();

    // 4: overrun
    ovr_clr = 1'b0;
    for (int i = 0; i <= 16; i++)
      bfm_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    check("t4_level_full", 32'(rx_level0), 16);
    check("t4_overrun_cnt", 32'(ovr_cnt), 1);
    check("t4_rx_valid", 32'(rx_valid0), 1);
    rx_ready0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_pop%0d", i), 32'(rx_data0), 32'(i));
      @(negedge clk);
    end
    rx_ready0 = 1'b0;
    check("t4_level_empty", 32'(rx_level0), 0);
    check("t4_valid_empty", 32'(rx_valid0), 0);
    ovr_clr = 1'b1;

    // 5: glitch rejection, then TX backpressure
    rxd_b0 = 1'b0;
    repeat (20) @(negedge clk);
    rxd_b0 = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_glitch_valid", 32'(rx_valid0), 0);
    check("t5_glitch_level", 32'(rx_level0), 0);
    loop0 = 1'b1;
    mon_en = 1'b1;
    rx_ready0 = 1'b1;
    saw_full = 1'b0;
    rdy_at_full = 1'b1;
    k = 0;
    n = 0;
    tx_valid0 = 1'b1;
    while (k < 20 && n < 30000) begin
      tx_data0 = 8'h30 + 8'(k);
      acc = tx_ready0;
      if (tx_level0 == 5'd16) begin
        saw_full = 1'b1;
        rdy_at_full = tx_ready0;
      end
      @(negedge clk);
      n++;
      if (acc) k++;
    end
    tx_valid0 = 1'b0;
    check("t5_all_pushed", 32'(k), 20);
    check("t5_saw_full", 32'(saw_full), 1);
    check("t5_ready_at_full", 32'(rdy_at_full), 0);
    n = 0;
    while (rxq.size() < 20 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    check("t5_rx_count", 32'(rxq.size()), 20);
    for (int i = 0; i < 20 && i < rxq.size(); i++)
      check($sformatf("t5_order%0d", i), 32'(rxq[i]), 32'h30 + 32'(i));
    rx_ready0 = 1'b0;
    mon_en = 1'b0;
    loop0 = 1'b0;
    repeat (200) @(negedge clk);

    // 6: reset mid-TX and mid-RX
    tx_data0 = 8'h00;
    tx_valid0 = 1'b1;
    @(negedge clk);
    tx_data0 = 8'h11;
    @(negedge clk);
    tx_valid0 = 1'b0;
    wait_fall(1'b0, 500, ok);
    check("t6_tx_start", 32'(ok), 1);
    repeat (200) @(negedge clk);
    check("t6_mid_txd", 32'(txd0), 0);
    check("t6_mid_level", 32'(tx_level0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_txd", 32'(txd0), 1);
    check("t6_rst_tx_level", 32'(tx_level0), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t6_idle_txd", 32'(txd0), 1);
    rxd_b0 = 1'b0;
    repeat (96 * 4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rxd_b0 = 1'b1;
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    check("t6_rx_none", 32'(rx_level0), 0);
    bfm_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 500, ok);
    check("t6_rx_wait", 32'(ok), 1);
    check("t6_rx_data", 32'(rx_data0), 32'h5A);
    check("t6_rx_errs", 32'({rx_ferr0, rx_perr0}), 0);
    check("t6_rx_level", 32'(rx_level0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
